// File: rtl/multdiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: pipeline op codes,
// FSM state encoding, default iteration count and an operand magnitude helper.
package multdiv_pkg;

    localparam int ITER_DEFAULT = 32;

    localparam logic [4:0] ALU_OP_MULT = 5'b00110;
    localparam logic [4:0] ALU_OP_DIV  = 5'b00111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // 0x80000000 maps to itself, which reads correctly as an unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// 33-bit adder/subtractor with carry-out, shared by the multiply add step and
// the divide trial subtract (carry-out set means no borrow).
module multdiv_addsub (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] sum,
    output logic        cout
);

    logic [33:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {33'd0, sub};
    end

    assign sum  = full[32:0];
    assign cout = full[33];

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (shift-add) / divide (restoring) unit.
// state   | meaning
// IDLE    | waiting for a MULT or DIV start
// MUL     | one shift-add step per cycle, ITER steps
// DIV     | one restoring-divide step per cycle, ITER steps
// DONE    | result valid, data_resultRDY high for this one cycle
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam logic [5:0] LAST = 6'(ITER - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mag_q, mag_d;
    logic        sign_q, sign_d;
    logic        bz_q, bz_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;

    logic        start;
    logic [4:0]  start_op;
    logic [32:0] as_a, as_b, as_sum;
    logic        as_sub, as_cout;
    logic [63:0] step_acc, prod_s;
    logic [31:0] quo_s;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign start_op = ctrl_MULT ? ALU_OP_MULT : ALU_OP_DIV;

    // Multiply: acc = {partial product, remaining multiplier}, mag_q = |A|.
    // Divide:   acc = {partial remainder, dividend/quotient}, mag_q = |B|.
    always_comb begin
        as_a   = {1'b0, acc_q[63:32]};
        as_b   = acc_q[0] ? {1'b0, mag_q} : 33'd0;
        as_sub = 1'b0;
        if (state_q == ST_DIV) begin
            as_a   = {1'b0, acc_q[62:31]};
            as_b   = {1'b0, mag_q};
            as_sub = 1'b1;
        end
    end

    multdiv_addsub u_addsub (
        .a    (as_a),
        .b    (as_b),
        .sub  (as_sub),
        .sum  (as_sum),
        .cout (as_cout)
    );

    always_comb begin
        if (state_q == ST_DIV) begin
            step_acc = {(as_cout ? as_sum[31:0] : acc_q[62:31]), acc_q[30:0], as_cout};
        end else begin
            step_acc = {as_sum, acc_q[31:1]};
        end
        prod_s = sign_q ? (~step_acc + 64'd1) : step_acc;
        quo_s  = sign_q ? (~step_acc[31:0] + 32'd1) : step_acc[31:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mag_d    = mag_q;
        sign_d   = sign_q;
        bz_d     = bz_q;
        result_d = result_q;
        exc_d    = exc_q;

        case (state_q)
            ST_MUL, ST_DIV: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    if (state_q == ST_MUL) begin
                        result_d = prod_s[31:0];
                        exc_d    = prod_s[63:32] != {32{prod_s[31]}};
                    end else if (bz_q) begin
                        result_d = 32'd0;
                        exc_d    = 1'b1;
                    end else begin
                        // Only a positive quotient of magnitude 2^31 is unrepresentable.
                        result_d = quo_s;
                        exc_d    = step_acc[31] & ~sign_q;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: ;
        endcase

        if (start) begin
            state_d  = (start_op == ALU_OP_MULT) ? ST_MUL : ST_DIV;
            cnt_d    = 6'd0;
            sign_d   = data_operandA[31] ^ data_operandB[31];
            bz_d     = data_operandB == 32'd0;
            mag_d    = ctrl_MULT ? mag32(data_operandA) : mag32(data_operandB);
            acc_d    = {32'd0, (ctrl_MULT ? mag32(data_operandB) : mag32(data_operandA))};
            result_d = 32'd0;
            exc_d    = 1'b0;
        end

        rdy_d = state_d == ST_DONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= 64'd0;
            mag_q    <= 32'd0;
            sign_q   <= 1'b0;
            bz_q     <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mag_q    <= mag_d;
            sign_q   <= sign_d;
            bz_q     <= bz_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule
